// File: rtl/sb_ar_arbiter.sv
// sb_ar_arbiter
// Shares one AXI read channel between NUM_CELLS stream-buffer cells.
// AR requests from the cells are round-robin arbitrated onto the memory AR
// port one at a time. Returning R beats are steered back to the owning cell
// by RID, with no added latency.
//
// Handshake semantics (both AR sides): a transfer happens in a cycle where
// valid and ready are both high. A valid, once raised, stays high with a
// stable payload until that transfer. Ready may depend combinationally on
// valid. m_arvalid is raised only from the registered HOLD state. It is
// dropped before a transfer only by rst. RREADY is tied high, so every
// m_rvalid cycle is a beat.
module sb_ar_arbiter #(
    parameter int NUM_CELLS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int ID_BASE    = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    // cell side AR
    input  logic [NUM_CELLS-1:0][ADDR_WIDTH-1:0] cell_araddr,
    input  logic [NUM_CELLS-1:0][7:0]            cell_arlen,
    input  logic [NUM_CELLS-1:0][ID_WIDTH-1:0]   cell_arid,
    input  logic [NUM_CELLS-1:0]                 cell_arvalid,
    output logic [NUM_CELLS-1:0]                 cell_arready,
    // cell side R
    output logic [DATA_WIDTH-1:0]                cell_rdata,
    output logic [NUM_CELLS-1:0]                 cell_rvalid,
    output logic [NUM_CELLS-1:0]                 cell_rlast,
    // memory side AR
    output logic [ADDR_WIDTH-1:0]                m_araddr,
    output logic [7:0]                           m_arlen,
    output logic [ID_WIDTH-1:0]                  m_arid,
    output logic                                 m_arvalid,
    input  logic                                 m_arready,
    // memory side R
    input  logic [DATA_WIDTH-1:0]                m_rdata,
    input  logic [ID_WIDTH-1:0]                  m_rid,
    input  logic                                 m_rlast,
    input  logic                                 m_rvalid,
    output logic                                 m_rready,
    // status
    output logic [NUM_CELLS-1:0]                 busy,
    output logic                                 id_err,
    output logic                                 dbg_state
);

    localparam int CW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

    typedef logic [CW-1:0] cell_idx_t;

    // ARB: nothing held, pick a cell. HOLD: registered request on m_ar*.
    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Reject configurations the index arithmetic below cannot represent.
    if (NUM_CELLS < 2 || NUM_CELLS > 8) begin : g_bad_num_cells
        $error("sb_ar_arbiter: NUM_CELLS must be in 2..8");
    end
    if (ID_BASE < 0 || (ID_BASE + NUM_CELLS - 1) >= (1 << ID_WIDTH)) begin : g_bad_id_range
        $error("sb_ar_arbiter: cell ID range does not fit in ID_WIDTH");
    end

    state_t                 state_q;
    state_t                 state_d;
    cell_idx_t              rr_ptr_q;
    cell_idx_t              grant_q;
    logic [ADDR_WIDTH-1:0]  araddr_q;
    logic [7:0]             arlen_q;
    logic [ID_WIDTH-1:0]    arid_q;
    logic [NUM_CELLS-1:0]   busy_q;
    logic [NUM_CELLS-1:0]   busy_d;
    logic                   id_err_q;

    logic [NUM_CELLS-1:0]   eligible;
    logic                   pick_valid;
    cell_idx_t              pick_idx;
    logic                   load_grant;
    logic                   ar_hs;
    cell_idx_t              next_ptr;

    int                     rid_off;
    logic                   rid_in_range;
    cell_idx_t              rid_idx;
    logic                   beat_clear;

    // A cell with a burst still outstanding may not be granted again until
    // that burst has fully drained, so RID routing stays unambiguous.
    assign eligible = cell_arvalid & ~busy_q;

    // Round-robin pick: first eligible cell at or after rr_ptr, wrapping.
    // Scanning from the farthest offset down lets the nearest one win.
    always_comb begin
        int        cand;
        cell_idx_t cand_idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = NUM_CELLS - 1; k >= 0; k--) begin
            cand     = (int'(rr_ptr_q) + k) % NUM_CELLS;
            cand_idx = cell_idx_t'(cand);
            if (eligible[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and AR handshake outputs.
    always_comb begin
        state_d      = state_q;
        load_grant   = 1'b0;
        ar_hs        = 1'b0;
        m_arvalid    = 1'b0;
        cell_arready = '0;
        case (state_q)
            ST_ARB: begin
                if (pick_valid) begin
                    load_grant = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    ar_hs                 = 1'b1;
                    cell_arready[grant_q] = 1'b1;
                    state_d               = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // Capture the winning cell and its payload so m_ar* stays stable in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q  <= '0;
            araddr_q <= '0;
            arlen_q  <= '0;
            arid_q   <= '0;
        end else if (load_grant) begin
            grant_q  <= pick_idx;
            araddr_q <= cell_araddr[pick_idx];
            arlen_q  <= cell_arlen[pick_idx];
            arid_q   <= cell_arid[pick_idx];
        end
    end

    // The cell just served becomes lowest priority on the next round.
    assign next_ptr = (grant_q == cell_idx_t'(NUM_CELLS - 1)) ? '0 : grant_q + 1'b1;

    // Round-robin pointer advances only on an accepted AR.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (ar_hs) begin
            rr_ptr_q <= next_ptr;
        end
    end

    // Decode RID into a cell index. RIDs below ID_BASE go negative and are
    // rejected together with the ones past the last cell.
    always_comb begin
        rid_off      = int'(m_rid) - ID_BASE;
        rid_in_range = (rid_off >= 0) && (rid_off < NUM_CELLS);
        rid_idx      = rid_in_range ? cell_idx_t'(rid_off) : '0;
    end

    // Steer R beats to the owning cell. Data is broadcast, and valid/last
    // reach only the addressed cell. Out-of-range beats are dropped.
    always_comb begin
        cell_rvalid = '0;
        cell_rlast  = '0;
        if (rid_in_range) begin
            cell_rvalid[rid_idx] = m_rvalid;
            cell_rlast[rid_idx]  = m_rvalid & m_rlast;
        end
    end

    assign beat_clear = m_rvalid & m_rlast & rid_in_range;

    // Busy bookkeeping. A set (new grant) and a clear (last beat) in the same
    // cycle always target different cells, so both are applied.
    always_comb begin
        busy_d = busy_q;
        if (beat_clear) begin
            busy_d[rid_idx] = 1'b0;
        end
        if (ar_hs) begin
            busy_d[grant_q] = 1'b1;
        end
    end

    // Busy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Sticky flag for a beat whose RID belongs to no attached cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_err_q <= 1'b0;
        end else if (m_rvalid && !rid_in_range) begin
            id_err_q <= 1'b1;
        end
    end

    assign m_araddr   = araddr_q;
    assign m_arlen    = arlen_q;
    assign m_arid     = arid_q;
    assign m_rready   = 1'b1;
    assign cell_rdata = m_rdata;
    assign busy       = busy_q;
    assign id_err     = id_err_q;
    assign dbg_state  = (state_q == ST_HOLD);

endmodule

// File: tb/tb_sb_ar_arbiter.sv
// tb_sb_ar_arbiter
// Bench for sb_ar_arbiter. It uses a scoreboard of expected AR transfers,
// a table of R-routing vectors, and hand-written multi-cycle sequences.
module tb_sb_ar_arbiter;

    localparam int NC = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int IB = 2;
    localparam int EW = IW + 8 + AW;

    // clock / reset
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DUT signals
    logic [NC-1:0][AW-1:0] cell_araddr;
    logic [NC-1:0][7:0]    cell_arlen;
    logic [NC-1:0][IW-1:0] cell_arid;
    logic [NC-1:0]         cell_arvalid;
    logic [NC-1:0]         cell_arready;
    logic [DW-1:0]         cell_rdata;
    logic [NC-1:0]         cell_rvalid;
    logic [NC-1:0]         cell_rlast;
    logic [AW-1:0]         m_araddr;
    logic [7:0]            m_arlen;
    logic [IW-1:0]         m_arid;
    logic                  m_arvalid;
    logic                  m_arready;
    logic [DW-1:0]         m_rdata;
    logic [IW-1:0]         m_rid;
    logic                  m_rlast;
    logic                  m_rvalid;
    logic                  m_rready;
    logic [NC-1:0]         busy;
    logic                  id_err;
    logic                  dbg_state;

    sb_ar_arbiter #(
        .NUM_CELLS (NC),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .ID_WIDTH  (IW),
        .ID_BASE   (IB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cell_araddr (cell_araddr),
        .cell_arlen  (cell_arlen),
        .cell_arid   (cell_arid),
        .cell_arvalid(cell_arvalid),
        .cell_arready(cell_arready),
        .cell_rdata  (cell_rdata),
        .cell_rvalid (cell_rvalid),
        .cell_rlast  (cell_rlast),
        .m_araddr    (m_araddr),
        .m_arlen     (m_arlen),
        .m_arid      (m_arid),
        .m_arvalid   (m_arvalid),
        .m_arready   (m_arready),
        .m_rdata     (m_rdata),
        .m_rid       (m_rid),
        .m_rlast     (m_rlast),
        .m_rvalid    (m_rvalid),
        .m_rready    (m_rready),
        .busy        (busy),
        .id_err      (id_err),
        .dbg_state   (dbg_state)
    );

    // scoreboard
    logic [EW-1:0] exp_q[$];
    int n_checks;
    int n_errors;
    bit keep_req;
    bit auto_resp;
    bit resp_pending;

    // R routing vector table
    typedef struct {
        logic          rv;
        logic [IW-1:0] rid;
        logic          rl;
        logic [DW-1:0] data;
        logic [NC-1:0] exp_rv;
        logic [NC-1:0] exp_rl;
        logic [NC-1:0] exp_busy;
    } rvec_t;

    rvec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Push the AR transfer expected from cell i, built from what the bench drives.
    task automatic push_exp(input int i);
        exp_q.push_back({cell_arid[i], cell_arlen[i], cell_araddr[i]});
    endtask

    task automatic req(input int i, input logic [AW-1:0] a, input logic [7:0] l);
        cell_araddr[i]  = a;
        cell_arlen[i]   = l;
        cell_arid[i]    = IW'(IB + i);
        cell_arvalid[i] = 1'b1;
    endtask

    // One clock: check AR transfers at the negedge, then step past the
    // posedge. It acts as the cells (drop arvalid) and as the memory
    // (one-beat response).
    task automatic tick();
        logic [EW-1:0] e;
        logic [NC-1:0] oh;
        int            gi;
        bit            popped;
        popped = 1'b0;
        gi     = 0;
        oh     = '0;
        @(negedge clk);
        if (m_arvalid && m_arready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_grant: got arid 0x%0h expected none", m_arid);
            end else begin
                e      = exp_q.pop_front();
                popped = 1'b1;
                gi     = int'(e[EW-1 -: IW]) - IB;
                oh[gi] = 1'b1;
                chk("ar_payload", {m_arid, m_arlen, m_araddr}, e);
                chk("ar_ready_onehot", cell_arready, oh);
            end
        end
        @(posedge clk);
        #1;
        if (resp_pending) begin
            m_rvalid     = 1'b0;
            m_rlast      = 1'b0;
            resp_pending = 1'b0;
        end
        if (popped) begin
            if (!keep_req) cell_arvalid[gi] = 1'b0;
            if (auto_resp) begin
                m_rvalid     = 1'b1;
                m_rid        = IW'(gi + IB);
                m_rlast      = 1'b1;
                resp_pending = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        m_arready    = 1'b0;
        cell_arvalid = '0;
        m_rvalid     = 1'b0;
        m_rlast      = 1'b0;
        m_rid        = '0;
        keep_req     = 1'b0;
        auto_resp    = 1'b0;
        resp_pending = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Grant one cell with immediate m_arready and leave it busy.
    task automatic grant_one(input int i, input logic [AW-1:0] a, input logic [7:0] l);
        req(i, a, l);
        m_arready = 1'b1;
        push_exp(i);
        tick();
        tick();
        m_arready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        n_checks     = 0;
        n_errors     = 0;
        cell_araddr  = '0;
        cell_arlen   = '0;
        cell_arid    = '0;
        cell_arvalid = '0;
        m_arready    = 1'b0;
        m_rdata      = '0;
        m_rid        = '0;
        m_rlast      = 1'b0;
        m_rvalid     = 1'b0;
        rst          = 1'b1;

        tbl[0] = '{1'b1, IW'(IB + 3), 1'b0, $urandom(), 4'b1000, 4'b0000, 4'b1000};
        tbl[1] = '{1'b1, IW'(IB + 3), 1'b0, $urandom(), 4'b1000, 4'b0000, 4'b1000};
        tbl[2] = '{1'b0, IW'(IB + 3), 1'b0, $urandom(), 4'b0000, 4'b0000, 4'b1000};
        tbl[3] = '{1'b1, IW'(IB + 3), 1'b0, $urandom(), 4'b1000, 4'b0000, 4'b1000};
        tbl[4] = '{1'b1, IW'(IB + 3), 1'b1, $urandom(), 4'b1000, 4'b1000, 4'b0000};
        tbl[5] = '{1'b1, IW'(IB + 0), 1'b1, $urandom(), 4'b0001, 4'b0001, 4'b0000};
        tbl[6] = '{1'b1, IW'(IB + 1), 1'b0, $urandom(), 4'b0010, 4'b0000, 4'b0000};
        tbl[7] = '{1'b0, IW'(IB + 2), 1'b0, $urandom(), 4'b0000, 4'b0000, 4'b0000};

        // reset state
        do_reset();
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_cell_arready", cell_arready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_id_err", id_err, 0);
        chk("rst_m_rready", m_rready, 1);
        chk("rst_cell_rvalid", cell_rvalid, 0);

        // single request from cell 1
        req(1, 32'h8000_0040, 8'd4);
        m_arready = 1'b1;
        #1;
        chk("single_arvalid_early", m_arvalid, 0);
        chk("single_arready_early", cell_arready, 0);
        push_exp(1);
        tick();
        chk("single_arvalid", m_arvalid, 1);
        chk("single_dbg_hold", dbg_state, 1);
        chk("single_arid", m_arid, IB + 1);
        chk("single_araddr", m_araddr, 32'h8000_0040);
        chk("single_arlen", m_arlen, 4);
        chk("single_arready", cell_arready, 4'b0010);
        chk("single_busy_pre", busy, 0);
        tick();
        chk("single_busy", busy, 4'b0010);
        chk("single_arvalid_drop", m_arvalid, 0);
        chk("single_arready_drop", cell_arready, 0);
        tick();
        chk("single_idle", m_arvalid, 0);

        // round robin with all cells requesting continuously
        do_reset();
        for (int i = 0; i < NC; i++) req(i, 32'h1000_0000 + 32'(i * 64), 8'(i + 1));
        m_arready = 1'b1;
        keep_req  = 1'b1;
        auto_resp = 1'b1;
        push_exp(0);
        push_exp(1);
        push_exp(2);
        push_exp(3);
        push_exp(0);
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rr_timeout: got %0d grants left expected 0", exp_q.size());
        end else begin
            chk("rr_cycles", n, 10);
        end
        cell_arvalid = '0;
        keep_req     = 1'b0;
        auto_resp    = 1'b0;

        // busy exclusion: cell 2 re-requests while busy
        do_reset();
        grant_one(2, 32'h2000_0100, 8'd3);
        chk("excl_busy", busy, 4'b0100);
        cell_arvalid[2] = 1'b1;
        m_arready       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("excl_no_grant", m_arvalid, 0);
        end
        m_rvalid = 1'b1;
        m_rid    = IW'(IB + 2);
        m_rlast  = 1'b1;
        #1;
        chk("excl_beat_route", cell_rvalid, 4'b0100);
        push_exp(2);
        tick();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        chk("excl_busy_cleared", busy, 0);
        chk("excl_not_yet", m_arvalid, 0);
        tick();
        chk("excl_regrant", m_arvalid, 1);
        tick();
        chk("excl_sb_empty", exp_q.size(), 0);
        cell_arvalid = '0;

        // routing table against a busy cell 3
        do_reset();
        grant_one(3, 32'h3000_0000, 8'd3);
        chk("route_busy3", busy, 4'b1000);
        for (int i = 0; i < 8; i++) begin
            m_rvalid = tbl[i].rv;
            m_rid    = tbl[i].rid;
            m_rlast  = tbl[i].rl;
            m_rdata  = tbl[i].data;
            #1;
            chk("route_rvalid", cell_rvalid, tbl[i].exp_rv);
            chk("route_rlast", cell_rlast, tbl[i].exp_rl);
            chk("route_rdata", cell_rdata, tbl[i].data);
            tick();
            chk("route_busy", busy, tbl[i].exp_busy);
        end
        chk("route_no_id_err", id_err, 0);

        // bad ID, stall, then reset
        do_reset();
        grant_one(1, 32'h4000_0000, 8'd0);
        m_rvalid = 1'b1;
        m_rid    = IW'(IB + NC);
        m_rlast  = 1'b1;
        #1;
        chk("badid_rvalid", cell_rvalid, 0);
        chk("badid_rlast", cell_rlast, 0);
        tick();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        chk("badid_err", id_err, 1);
        chk("badid_busy_kept", busy, 4'b0010);
        tick();
        tick();
        chk("badid_sticky", id_err, 1);
        req(0, 32'hCAFE_0080, 8'd7);
        m_arready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_arvalid", m_arvalid, 1);
            chk("stall_payload", {m_arid, m_arlen, m_araddr}, {4'(IB), 8'd7, 32'hCAFE_0080});
            chk("stall_arready", cell_arready, 0);
            tick();
        end
        rst             = 1'b1;
        cell_arvalid[0] = 1'b0;
        m_rvalid        = 1'b1;
        m_rid           = IW'(IB + 1);
        m_rlast         = 1'b1;
        #1;
        chk("rst_inflight_route", cell_rvalid, 4'b0010);
        tick();
        rst      = 1'b0;
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        chk("rst_mid_arvalid", m_arvalid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_id_err", id_err, 0);

        // RID below the base is also out of range
        m_rvalid = 1'b1;
        m_rid    = IW'(IB - 1);
        m_rlast  = 1'b1;
        #1;
        chk("lowid_rvalid", cell_rvalid, 0);
        tick();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        chk("lowid_err", id_err, 1);

        chk("scoreboard_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
